iso_domain_seq: RTL and testbench

Power-domain sequencer for the isolated arithmetic datapath, the 16-bit SC_UNIT array whose inputs sit behind `Iso_FL_1P`/`Iso_TH_1P` clamp cells. On request it powers the domain down or up in a fixed order: isolation, then power switch, then acknowledge. It drives the datapath's top-level active-high `iso` pin and the domain's power-switch enable. It is the only block allowed to toggle `iso`.

---
 rtl/iso_seq_pkg.sv | 21 ++
 rtl/iso_seq_timer.sv | 21 ++
 rtl/iso_domain_seq.sv | 72 +++++++
 tb/tb_iso_domain_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/iso_seq_pkg.sv
// iso_seq_pkg: state encoding and timer sizing for the isolation-domain sequencer
package iso_seq_pkg;
  typedef enum logic [2:0] {
    OFF       = 3'd0,
    SW_ON     = 3'd1,
    ISO_HOLD  = 3'd2,
    ON        = 3'd3,
    ISO_SETUP = 3'd4,
    SW_OFF    = 3'd5,
    ERR       = 3'd6
  } iso_state_e;

  function automatic int tmr_w(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m) + 1;
  endfunction

  localparam int TMR_W = tmr_w(4, 3, 16);
endpackage

// File: rtl/iso_seq_timer.sv
// iso_seq_timer: loadable down-counter; expired flags the last cycle of a loaded interval
module iso_seq_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end

  // loading N makes the Nth following edge the expiring one
  assign expired = cnt == W'(1);
endmodule

// File: rtl/iso_domain_seq.sv
// iso_domain_seq: orders isolation, power switch and acknowledge for the clamped SC_UNIT domain
module iso_domain_seq
  import iso_seq_pkg::*;
#(
  parameter int ISO_SETUP_CYC = 4,
  parameter int ISO_HOLD_CYC  = 3,
  parameter int SW_TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwr_req,
  output logic       pwr_ack,
  output logic       iso,
  output logic       sw_en,
  input  logic       sw_ack,
  output logic       err,
  input  logic       err_clr,
  output logic [2:0] state_o
);
  localparam int TW = tmr_w(ISO_SETUP_CYC, ISO_HOLD_CYC, SW_TIMEOUT);

  iso_state_e st, nx;
  logic [1:0] sync;
  logic sw_ack_s, ld, tmr_exp;
  logic [TW-1:0] val;

  assign sw_ack_s = sync[1];
  assign state_o  = st;

  always_comb begin
    nx = st;
    case (st)
      OFF:       nx = pwr_req ? SW_ON : OFF;
      SW_ON:     nx = sw_ack_s ? ISO_HOLD : tmr_exp ? ERR : SW_ON;
      ISO_HOLD:  nx = tmr_exp ? ON : ISO_HOLD;
      ON:        nx = pwr_req ? ON : ISO_SETUP;
      ISO_SETUP: nx = tmr_exp ? SW_OFF : ISO_SETUP;
      SW_OFF:    nx = !sw_ack_s ? OFF : tmr_exp ? ERR : SW_OFF;
      ERR:       nx = err_clr ? OFF : ERR;
      default:   nx = OFF;
    endcase
    ld  = nx != st && nx inside {SW_ON, ISO_HOLD, ISO_SETUP, SW_OFF};
    val = nx == ISO_HOLD ? TW'(ISO_HOLD_CYC) : nx == ISO_SETUP ? TW'(ISO_SETUP_CYC) : TW'(SW_TIMEOUT);
  end

  iso_seq_timer #(.W(TW)) u_tmr (
    .clk(clk),
    .rst(rst),
    .load(ld),
    .value(val),
    .expired(tmr_exp)
  );

  // outputs decode the next state so they move on the edge that enters it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= '0;
      st      <= OFF;
      iso     <= 1'b1;
      sw_en   <= 1'b0;
      pwr_ack <= 1'b0;
      err     <= 1'b0;
    end else begin
      sync    <= {sync[0], sw_ack};
      st      <= nx;
      iso     <= nx != ON;
      sw_en   <= nx inside {SW_ON, ISO_HOLD, ON, ISO_SETUP};
      pwr_ack <= nx == ON;
      err     <= nx == ERR;
    end
  end
endmodule

// File: tb/tb_iso_domain_seq.sv
// tb_iso_domain_seq: directed scenarios plus randomized traffic against a dwell-time reference model
module tb_iso_domain_seq;
  import iso_seq_pkg::*;

  localparam int S = 4, H = 3, T = 16;

  logic clk = 1'b0, rst = 1'b1, pwr_req = 1'b0, sw_ack = 1'b0, err_clr = 1'b0;
  logic pwr_ack, iso, sw_en, err;
  logic [2:0] state_o;
  int total = 0, bad = 0, cyc = 0, stuck = 0;

  iso_domain_seq #(.ISO_SETUP_CYC(S), .ISO_HOLD_CYC(H), .SW_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .pwr_req(pwr_req), .pwr_ack(pwr_ack), .iso(iso),
    .sw_en(sw_en), .sw_ack(sw_ack), .err(err), .err_clr(err_clr), .state_o(state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // switch chain: follows sw_en one cycle late unless forced stuck low (1) or high (2)
  always @(posedge clk) sw_ack <= stuck == 1 ? 1'b0 : stuck == 2 ? 1'b1 : sw_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d @%0t", nm, act, want, $time);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim && at < 0; i++) begin
      @(negedge clk);
      if (state_o == s) at = cyc;
    end
    total++;
    if (at < 0) begin
      bad++;
      $display("FAIL wait_state: got timeout want state %0d @%0t", s, $time);
    end
  endtask

  // reference: state plus edges spent in it; synced ack is the sample taken two edges back
  iso_state_e m_st = OFF;
  int dwell = 0;
  logic [1:0] ah = '0;

  function automatic iso_state_e step(input iso_state_e s, input int d, input logic a,
                                      input logic req, input logic clr);
    case (s)
      OFF:       return req ? SW_ON : OFF;
      SW_ON:     return a ? ISO_HOLD : (d == T ? ERR : SW_ON);
      ISO_HOLD:  return d == H ? ON : ISO_HOLD;
      ON:        return req ? ON : ISO_SETUP;
      ISO_SETUP: return d == S ? SW_OFF : ISO_SETUP;
      SW_OFF:    return !a ? OFF : (d == T ? ERR : SW_OFF);
      ERR:       return clr ? OFF : ERR;
      default:   return OFF;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st  <= OFF;
      dwell <= 0;
      ah    <= '0;
    end else begin
      m_st  <= step(m_st, dwell + 1, ah[1], pwr_req, err_clr);
      dwell <= step(m_st, dwell + 1, ah[1], pwr_req, err_clr) == m_st ? dwell + 1 : 0;
      ah    <= {ah[0], sw_ack};
    end
  end

  always @(negedge clk) begin
    chk("iso", 32'(iso), 32'(m_st != ON));
    chk("sw_en", 32'(sw_en), 32'(m_st inside {SW_ON, ISO_HOLD, ON, ISO_SETUP}));
    chk("pwr_ack", 32'(pwr_ack), 32'(m_st == ON));
    chk("err", 32'(err), 32'(m_st == ERR));
    chk("state", 32'(state_o), 32'(m_st));
    if (iso === 1'b0) chk("iso_low_invariant", 32'({sw_en, state_o == 3'(ON)}), 32'd3);
  end

  initial begin
    int n, at, acks, r;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_state", 32'(state_o), 32'(OFF));
    chk("rst_iso", 32'(iso), 32'd1);
    chk("rst_sw_en", 32'(sw_en), 32'd0);
    chk("rst_ack", 32'(pwr_ack), 32'd0);

    pwr_req = 1'b1; n = cyc + 1;
    @(negedge clk);
    chk("up_sw_en", 32'(sw_en), 32'd1);
    chk("up_iso", 32'(iso), 32'd1);
    wait_state(ON, 20, at);
    chk("up_latency", 32'(at), 32'(n + 7));
    chk("up_ack", 32'(pwr_ack), 32'd1);
    chk("up_iso_low", 32'(iso), 32'd0);

    repeat (3) @(negedge clk);
    pwr_req = 1'b0; n = cyc + 1;
    @(negedge clk);
    chk("dn_iso", 32'(iso), 32'd1);
    chk("dn_ack", 32'(pwr_ack), 32'd0);
    wait_state(SW_OFF, 20, at);
    chk("dn_sw_latency", 32'(at), 32'(n + 4));
    chk("dn_sw_en", 32'(sw_en), 32'd0);
    wait_state(OFF, 20, at);
    chk("dn_off_latency", 32'(at), 32'(n + 8));

    stuck = 1;
    @(negedge clk);
    pwr_req = 1'b1; n = cyc + 1;
    wait_state(ERR, 40, at);
    chk("timeout_latency", 32'(at), 32'(n + 16));
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_sw_en", 32'(sw_en), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pwr_req = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chk("err_ignores_req", 32'(state_o), 32'(ERR));
    pwr_req = 1'b0; err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr_state", 32'(state_o), 32'(OFF));
    chk("err_clr_flag", 32'(err), 32'd0);
    stuck = 0;

    @(negedge clk);
    pwr_req = 1'b1;
    wait_state(ISO_HOLD, 20, at);
    pwr_req = 1'b0; acks = 0;
    repeat (30) begin
      @(negedge clk);
      acks += int'(pwr_ack);
    end
    chk("hold_drop_ack_pulse", 32'(acks), 32'd1);
    chk("hold_drop_off", 32'(state_o), 32'(OFF));

    pwr_req = 1'b1;
    wait_state(ON, 20, at);
    pwr_req = 1'b0;
    wait_state(ISO_SETUP, 5, at);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(state_o), 32'(OFF));
    chk("async_rst_sw_en", 32'(sw_en), 32'd0);
    chk("async_rst_iso", 32'(iso), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pwr_req = 1'b1; n = cyc + 1;
    wait_state(ON, 20, at);
    chk("post_rst_up_latency", 32'(at), 32'(n + 7));

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i % 250 == 0) begin
        r = int'($urandom_range(0, 3));
        stuck = r < 2 ? 0 : r - 1;
      end
      if ($urandom_range(0, 99) < 5) pwr_req = ~pwr_req;
      err_clr = $urandom_range(0, 29) == 0;
    end
    err_clr = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
